psum_accum_sfu: RTL and testbench

- Sits directly downstream of the corelet output FIFO.
- Consumes one column-vector of partial sums per valid beat and accumulates them across all kij passes into an nij-indexed buffer.
- Once the final kij pass completes, drains the results with per-column ReLU through a valid/ready handshake toward psum memory.

---
 rtl/psum_accum_sfu_if.sv | 26 ++
 rtl/psum_accum_sfu.sv | 164 ++++++++++++++++
 tb/tb_psum_accum_sfu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/psum_accum_sfu_if.sv
// Stream bundle between the ofifo side, the accumulator and psum memory.
// The master drives the job control and input beats, and accepts the drained output.
interface psum_accum_sfu_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic                   start;
  logic [col*psum_bw-1:0] in_psum;
  logic                   in_valid;
  logic [col*psum_bw-1:0] out_psum;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, in_psum, in_valid, out_ready,
    input  out_psum, out_valid, busy, done, err
  );

  modport slave (
    input  start, in_psum, in_valid, out_ready,
    output out_psum, out_valid, busy, done, err
  );
endinterface

// File: rtl/psum_accum_sfu.sv
// Accumulates kij passes of column psum vectors into an nij-indexed buffer.
// After the last pass, the buffer is drained with per-lane ReLU over valid/ready.

// Per-lane datapath: first-pass load or saturating add, and ReLU on the drain read.
module psum_lane_sat #(
  parameter int BW = 16
) (
  input  logic [BW-1:0] acc,
  input  logic [BW-1:0] psum,
  input  logic [BW-1:0] drn,
  input  logic          first,
  output logic [BW-1:0] sum,
  output logic [BW-1:0] relu,
  output logic          sat
);
  logic [BW:0] wide;
  logic        ovf;

  assign wide = {acc[BW-1], acc} + {psum[BW-1], psum};
  // The two top bits of the sign-extended sum disagree only on overflow.
  assign ovf  = wide[BW] ^ wide[BW-1];

  // Pass 0 overwrites stale contents; later passes clamp to the signed range.
  always_comb begin
    sum = psum;
    sat = 1'b0;
    if (!first) begin
      if (ovf) begin
        sat = 1'b1;
        sum = wide[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      end else begin
        sum = wide[BW-1:0];
      end
    end
  end

  assign relu = drn[BW-1] ? '0 : drn;
endmodule

module psum_accum_sfu #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int nij_len = 36,
  parameter int kij_len = 9
) (
  input logic             clk,
  input logic             reset,
  psum_accum_sfu_if.slave bus
);
  localparam int NW = (nij_len > 1) ? $clog2(nij_len) : 1;
  localparam int KW = (kij_len > 1) ? $clog2(kij_len) : 1;
  localparam logic [NW-1:0] NIJ_LAST = NW'(nij_len - 1);
  localparam logic [KW-1:0] KIJ_LAST = KW'(kij_len - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  typedef logic [col-1:0][psum_bw-1:0] vec_t;

  state_t        state_q, state_d;
  logic [NW-1:0] nij_cnt, drain_idx, drain_sel;
  logic [KW-1:0] kij_cnt;
  vec_t          acc_mem [nij_len];
  vec_t          in_vec, rd_acc, rd_drn, wr_vec, relu_vec;
  logic [col-1:0] lane_sat;
  logic          beat_acc, last_beat, accept, last_acc;

  assign in_vec    = bus.in_psum;
  assign beat_acc  = (state_q == ACCUM) && bus.in_valid;
  assign last_beat = beat_acc && (nij_cnt == NIJ_LAST) && (kij_cnt == KIJ_LAST);
  assign accept    = (state_q == DRAIN) && bus.out_valid && bus.out_ready;
  assign last_acc  = accept && (drain_idx == NIJ_LAST);
  // Look ahead one entry on acceptance so the next beat is ready without a bubble.
  assign drain_sel = (accept && !last_acc) ? drain_idx + 1'b1 : drain_idx;
  assign rd_acc    = acc_mem[nij_cnt];
  assign rd_drn    = acc_mem[drain_sel];

  for (genvar c = 0; c < col; c++) begin : g_lane
    psum_lane_sat #(.BW(psum_bw)) u_lane (
      .acc   (rd_acc[c]),
      .psum  (in_vec[c]),
      .drn   (rd_drn[c]),
      .first (kij_cnt == '0),
      .sum   (wr_vec[c]),
      .relu  (relu_vec[c]),
      .sat   (lane_sat[c])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and busy flag.
  always_comb begin
    state_d  = state_q;
    bus.busy = (state_q != IDLE);
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (last_beat) state_d = DRAIN;
      DRAIN:   if (last_acc)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Buffer write; contents are not reset because pass 0 overwrites every entry.
  always_ff @(posedge clk) begin
    if (reset && beat_acc) acc_mem[nij_cnt] <= wr_vec;
  end

  // Counters, drain output register, done pulse and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nij_cnt       <= '0;
      kij_cnt       <= '0;
      drain_idx     <= '0;
      bus.out_psum  <= '0;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            nij_cnt <= '0;
            kij_cnt <= '0;
            bus.err <= 1'b0;
          end
          if (bus.in_valid) bus.err <= 1'b1;
        end
        ACCUM: begin
          if (bus.in_valid) begin
            if (|lane_sat) bus.err <= 1'b1;
            if (nij_cnt == NIJ_LAST) begin
              nij_cnt <= '0;
              kij_cnt <= last_beat ? '0 : kij_cnt + 1'b1;
            end else begin
              nij_cnt <= nij_cnt + 1'b1;
            end
            if (last_beat) drain_idx <= '0;
          end
        end
        DRAIN: begin
          if (bus.in_valid) bus.err <= 1'b1;
          if (!bus.out_valid) begin
            bus.out_psum  <= relu_vec;
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            if (last_acc) begin
              bus.out_valid <= 1'b0;
              bus.done      <= 1'b1;
              drain_idx     <= '0;
            end else begin
              drain_idx    <= drain_idx + 1'b1;
              bus.out_psum <= relu_vec;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accum_sfu.sv
// Directed bench for psum_accum_sfu with a queue-based scoreboard on the drain port.
module tb_psum_accum_sfu;
  localparam int COL = 8, BW = 16, NIJ = 36, KIJ = 9;
  typedef logic [COL-1:0][BW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  psum_accum_sfu_if #(.col(COL), .psum_bw(BW)) bus ();
  psum_accum_sfu #(.col(COL), .psum_bw(BW), .nij_len(NIJ), .kij_len(KIJ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t sb[$];
  int   checks = 0, errors = 0, acc_cnt = 0;
  bit   done_due = 0, job_done = 0, hold_pend = 0;
  vec_t hold_val;

  task automatic chk(input string name, input logic [COL*BW-1:0] got, input logic [COL*BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted beat, checks hold stability and the done pulse.
  always @(negedge clk) begin
    vec_t e;
    if (!reset) begin
      done_due = 0; hold_pend = 0; acc_cnt = 0;
    end else begin
      if (done_due) begin
        chk("done_pulse", {127'd0, bus.done}, 128'd1);
        done_due = 0;
        job_done = 1;
      end else if (bus.done) begin
        chk("done_spurious", {127'd0, bus.done}, 128'd0);
      end
      if (hold_pend) begin
        chk("hold_valid", {127'd0, bus.out_valid}, 128'd1);
        chk("hold_stable", bus.out_psum, hold_val);
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = bus.out_psum;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=extra beat exp=none");
        end else begin
          e = sb.pop_front();
          chk($sformatf("out[%0d]", acc_cnt), bus.out_psum, e);
        end
        acc_cnt++;
        if (acc_cnt == NIJ) begin
          done_due = 1;
          acc_cnt  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: basic ramp, 1: all -3 (ReLU), 2: lane0 0x4000 (saturation)
  task automatic send_beats(input int kind, input int total);
    vec_t v;
    for (int b = 0; b < total; b++) begin
      for (int c = 0; c < COL; c++) begin
        case (kind)
          0:       v[c] = BW'(b % NIJ + b / NIJ);
          1:       v[c] = 16'hFFFD;
          default: v[c] = (c == 0) ? 16'h4000 : 16'h0001;
        endcase
      end
      bus.in_psum  = v;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_job(input int kind, input bit bp, input bit exp_err);
    vec_t e;
    job_done = 0;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_accum", {127'd0, bus.busy}, 128'd1);
    chk("err_cleared", {127'd0, bus.err}, 128'd0);
    send_beats(kind, NIJ * KIJ);
    for (int t = 0; t < NIJ; t++) begin
      for (int c = 0; c < COL; c++) begin
        case (kind)
          0:       e[c] = BW'(9 * t + 36);
          1:       e[c] = 16'h0000;
          default: e[c] = (c == 0) ? 16'h7FFF : 16'h0009;
        endcase
      end
      sb.push_back(e);
    end
    for (int i = 0; i < 400 && !job_done; i++) begin
      bus.out_ready = bp ? (i % 3 == 0) : 1'b1;
      tick();
    end
    bus.out_ready = 1'b1;
    if (!job_done) begin
      errors++;
      $display("FAIL job_timeout got=no done exp=done kind=%0d", kind);
    end
    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("err_final", {127'd0, bus.err}, {127'd0, exp_err});
    chk("busy_after", {127'd0, bus.busy}, 128'd0);
    chk("valid_after", {127'd0, bus.out_valid}, 128'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_psum = '0; bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (10) tick();
    chk("rst_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_busy", {127'd0, bus.busy}, 128'd0);
    chk("rst_done", {127'd0, bus.done}, 128'd0);
    chk("rst_err", {127'd0, bus.err}, 128'd0);
    chk("rst_psum", bus.out_psum, '0);
    reset = 1'b1;
    tick();
    chk("idle_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("idle_busy", {127'd0, bus.busy}, 128'd0);
    // Stray beat in IDLE is dropped but flagged.
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("idle_drop_err", {127'd0, bus.err}, 128'd1);
    chk("idle_drop_busy", {127'd0, bus.busy}, 128'd0);

    run_job(0, 1'b0, 1'b0);
    run_job(1, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b1);
    run_job(0, 1'b1, 1'b0);

    // Abort after pass 4 beat 10, then rerun the basic job cleanly.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send_beats(0, 4 * NIJ + 11);
    reset = 1'b0;
    tick();
    chk("abort_busy", {127'd0, bus.busy}, 128'd0);
    chk("abort_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("abort_done", {127'd0, bus.done}, 128'd0);
    reset = 1'b1;
    tick();
    run_job(0, 1'b0, 1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
